lane_sum_accumulator: RTL and testbench
=======================================

// Module: lane_sum_accumulator
// PURPOSE
//   Downstream consumer of the N-lane parallel adder: accepts the sum[N] vector, reduces the N signed
//   lanes to one total in a registered adder-tree stage, and accumulates FRAME_LEN totals into one
//   frame result. Results leave through a valid/ready output register. Any input gap and any output
//   backpressure are tolerated without loss.
// PARAMETERS
//   N         4    lane count; power of two, >= 2
//   W         8    signed lane width, matches the adder's W
//   FRAME_LEN 16   accepted input vectors per frame; >= 2
//   ACC_W     W+$clog2(N)+$clog2(FRAME_LEN)   result width; a full frame can never overflow
// PORTS
//   clk        in   1          clock; all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   clear      in   1          synchronous drop of the partial frame
//   in_valid   in   1          sum[] holds a valid vector
//   in_ready   out  1          block accepts sum[] this cycle
//   sum        in   W x [N]    signed lane sums (unpacked array, same shape as the adder output)
//   out_valid  out  1          out_data holds a completed frame result
//   out_ready  in   1          consumer takes out_data this cycle
//   out_data   out  ACC_W      signed frame total
// BEHAVIOUR
//   - Accept: in_valid && in_ready. Stage 1 registers s1_total = sign-extended sum of all N lanes (width W+log2N),
//     plus s1_valid and s1_last. s1_last = (frame count == FRAME_LEN-1) at accept time.
//   - Frame count: 0..FRAME_LEN-1. Increments on each accept and wraps to 0 after the last vector.
//   - Stage 2, when s1_valid and not stalled:
//       not s1_last: acc <= acc + s1_total
//       s1_last:     out_data <= acc + s1_total; out_valid <= 1; acc <= 0
//   - stall = s1_valid && s1_last && out_valid && !out_ready. While stalled, stage 1 holds its contents.
//     in_ready = !rst && !stall (combinational).
//   - Output handshake: out_valid && out_ready clears out_valid, unless a new result loads in the same cycle.
//     In that case out_valid stays 1 and out_data takes the new value.
//     out_data is stable while out_valid && !out_ready.
//   - Latency: last vector of a frame accepted at cycle t -> out_valid at t+2 if the output register is free.
//     Throughput is 1 vector/cycle when out_ready is held high.
//   - Arithmetic: all sums are signed two's complement with sign extension and no saturation.
//     ACC_W guarantees exact results. Range at defaults: -8192..8128.
//   - clear: count <= 0, s1_valid <= 0, acc <= 0. A vector offered in the same cycle is not accepted
//     (clear wins). A pending out_valid/out_data is unaffected. A stalled last vector held in stage 1 is discarded.
//   - rst: count, acc, s1_* <= 0; out_valid <= 0; out_data <= 0; in_ready = 0 while rst is high.
//     Reset mid-frame discards the partial frame and any pending result.
//   - Gaps: in_valid low for any number of cycles does not advance count or acc.
// TESTING
//   1. Reset: hold rst 3 cycles -> out_valid=0, out_data=0, in_ready=0 during rst. in_ready=1 the cycle after release.
//   2. Basic frame: out_ready=1, 16 back-to-back vectors with every lane=1 -> one out_valid pulse
//      2 cycles after the 16th accept, out_data=64.
//   3. Extremes: 16 vectors of all lanes=-128 -> -8192. Then 16 vectors of all lanes=127 -> 8128,
//      and frame 2 is not corrupted by frame 1.
//   4. Backpressure: out_ready=0, push 2 full frames (lanes=1, then lanes=2) -> first result 64 held stable.
//      in_ready drops once frame 2's last vector sits in stage 1. Raise out_ready -> 64 then 128 delivered in order.
//   5. clear: 5 vectors of lanes=3, then clear together with in_valid, then 16 vectors of lanes=2
//      -> single result 128; the 5 partial vectors and the clear-cycle vector are dropped.
//   6. Random: 8 frames of random lane values in -8..7, random in_valid gaps and random out_ready
//      -> every out_data equals the scoreboard frame sum; no result lost or duplicated.
//      Then assert rst mid-frame -> no output for the partial frame.

Source files
------------

// File: rtl/lane_sum_accumulator.sv
// Reduces N signed lane sums to one total per accepted vector, then accumulates
// FRAME_LEN totals into a frame result delivered through a valid/ready output register.
module lane_sum_accumulator #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = W + $clog2(N) + $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     sum [N],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
);

    localparam int S1_W  = W + $clog2(N);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Once out_valid is raised, out_data holds until the consumer takes it.
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [S1_W-1:0]  s1_total_q, s1_total_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;

    logic signed [S1_W-1:0]  lane_total;
    logic signed [ACC_W-1:0] s1_total_ext;
    logic                    stall;
    logic                    accept;
    logic                    s2_fire;

    always_comb begin
        lane_total = '0;
        for (int i = 0; i < N; i++) begin
            lane_total = lane_total + {{(S1_W - W){sum[i][W-1]}}, sum[i]};
        end
    end

    assign s1_total_ext = {{(ACC_W - S1_W){s1_total_q[S1_W-1]}}, s1_total_q};

    // Only a completed frame that cannot leave blocks the pipe; partial totals always drain into acc.
    assign stall    = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready && !clear;
    assign s2_fire  = s1_valid_q && !stall;

    always_comb begin
        count_d     = count_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_total_d  = s1_total_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s2_fire) begin
            if (s1_last_q) begin
                out_data_d  = acc_q + s1_total_ext;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + s1_total_ext;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_total_d = lane_total;
            s1_last_d  = (count_q == LAST_CNT);
            count_d    = (count_q == LAST_CNT) ? '0 : count_q + CNT_W'(1);
        end else if (!stall) begin
            s1_valid_d = 1'b0;
        end

        // Dropping the partial frame leaves any already-registered result alone.
        if (clear) begin
            count_d    = '0;
            s1_valid_d = 1'b0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_total_q  <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_total_q  <= s1_total_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lane_sum_accumulator.sv
// Bench for lane_sum_accumulator: directed frames with hand-computed totals, a random phase
// checked against a frame-sum model, and a queue-based monitor on the output handshake.
module tb_lane_sum_accumulator;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FL    = 16;
    localparam int ACC_W = W + $clog2(N) + $clog2(FL);

    logic                    clk;
    logic                    rst;
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     sum [N];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;

    logic [ACC_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    int m_sum = 0;
    bit auto_push  = 0;
    bit rand_ready = 0;

    lane_sum_accumulator #(.N(N), .W(W), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(ACC_W'(v));
    endtask

    // monitor: compares every presented result against the head of the queue
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got %0d, required no result", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL result_data: got %0d, required %0d", out_data, $signed(exp_q[0]));
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    // driver tasks (entered and left at posedge + 1)
    task automatic idle(input int n);
        repeat (n) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) sum[i] = W'(v);
    endtask

    task automatic send_cur();
        int  waited = 0;
        bit  got    = 0;
        int  s      = 0;
        in_valid = 1'b1;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else waited++;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", waited);
        end else begin
            for (int i = 0; i < N; i++) s += int'(sum[i]);
            m_sum += s;
            m_cnt++;
            if (m_cnt == FL) begin
                if (auto_push) push_exp(m_sum);
                m_cnt = 0;
                m_sum = 0;
            end
        end
    endtask

    task automatic send_frames(input int v, input int n);
        set_all(v);
        repeat (n) send_cur();
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_all(0);
        fork
            monitor_loop();
        join_none

        // 1. reset
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 2. basic frame and latency
        out_ready = 1'b1;
        push_exp(64);
        send_frames(1, FL);
        @(negedge clk);
        check("latency_t1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("latency_t2_valid", int'(out_valid), 1);
        @(negedge clk);
        check("single_pulse", int'(out_valid), 0);
        @(posedge clk);
        #1;
        drain("basic_drain");

        // 3. extremes, back to back
        push_exp(-8192);
        push_exp(8128);
        send_frames(-128, FL);
        send_frames(127, FL);
        drain("extremes_drain");

        // 4. backpressure
        out_ready = 1'b0;
        push_exp(64);
        push_exp(128);
        send_frames(1, FL);
        send_frames(2, FL);
        @(negedge clk);
        check("stall_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        idle(4);
        check("held_queue", exp_q.size(), 2);
        out_ready = 1'b1;
        drain("backpressure_drain");

        // 5. clear drops the partial frame and the clear-cycle vector
        push_exp(128);
        send_frames(3, 5);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        send_frames(2, FL);
        drain("clear_drain");

        // 6. random lanes, gaps and backpressure
        auto_push  = 1;
        rand_ready = 1;
        for (int f = 0; f < 8; f++) begin
            for (int v = 0; v < FL; v++) begin
                idle($urandom_range(0, 3));
                for (int i = 0; i < N; i++) sum[i] = W'($urandom_range(0, 15) - 8);
                send_cur();
            end
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        drain("random_drain");

        // reset mid-frame discards the partial frame
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) sum[i] = W'($urandom_range(0, 15) - 8);
            send_cur();
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        auto_push = 0;
        idle(30);
        check("no_output_after_rst", exp_q.size(), 0);
        push_exp(64);
        send_frames(1, FL);
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
